// File: rtl/counter_mode_seq.sv
`default_nettype none
// ============================================================================
// Module      : counter_mode_seq
// Description : Programmable mode sequencer feeding the 2-bit mode input of
//               the counter block. A table of (mode, length) segments is
//               loaded, then a start pulse plays the segments out
//               cycle-accurately on mode_out.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        : number of table entries (power of two, >= 2)
//   LEN_W        : width of each segment length in cycles
//   DEFAULT_MODE : mode_out value when not playing
// Ports
//   clk      in  : clock, all state updates on rising edge
//   rst      in  : synchronous active-low reset
//   wr_en    in  : table write strobe (accepted in IDLE / FIN only)
//   wr_addr  in  : entry index to write
//   wr_mode  in  : mode value for the entry
//   wr_len   in  : segment length, 0 marks end-of-program
//   start    in  : playback request (honoured in IDLE)
//   stop     in  : abort playback (honoured in RUN)
//   mode_out out : registered mode, drives the counter's mode input
//   seg_idx  out : index of the segment currently playing, 0 when idle
//   busy     out : high while playing
//   done     out : one-cycle pulse at the end of a completed pass
//   wr_err   out : one-cycle pulse when a write was rejected
// Configuration
//   COUNTER_MODE_SEQ_LOOP_EN : when defined, a completed pass restarts from
//   entry 0 with no gap; only stop or reset ends playback.
// ============================================================================
module counter_mode_seq #(
    parameter int         DEPTH        = 8,
    parameter int         LEN_W        = 8,
    parameter logic [1:0] DEFAULT_MODE = 2'd1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [1:0]               wr_mode,
    input  logic [LEN_W-1:0]         wr_len,
    input  logic                     start,
    input  logic                     stop,
    output logic [1:0]               mode_out,
    output logic [$clog2(DEPTH)-1:0] seg_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     wr_err
);

    localparam int AW = $clog2(DEPTH);

`ifdef COUNTER_MODE_SEQ_LOOP_EN
    localparam bit c_loop_en = 1'b1;
`else
    localparam bit c_loop_en = 1'b0;
`endif

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_fin  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_mode_tbl [DEPTH];
    logic [LEN_W-1:0] r_len_tbl  [DEPTH];
    logic [1:0]       r_mode_out;
    logic [AW-1:0]    r_seg_idx;
    logic [LEN_W-1:0] r_remain;
    logic             r_busy;
    logic             r_done;
    logic             r_wr_err;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_mode_nxt;
    logic [AW-1:0]    w_idx_nxt;
    logic [LEN_W-1:0] w_remain_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic [AW-1:0]    w_idx_inc;
    logic             w_seg_end;
    logic             w_pass_end;
    logic             w_start_ok;

    assign w_idx_inc  = r_seg_idx + AW'(1);
    // remain never reaches 0 in RUN; <= 1 keeps the decode safe regardless
    assign w_seg_end  = (r_remain <= LEN_W'(1));
    // End of pass: wrap past the last entry, or the next entry is a terminator
    assign w_pass_end = (r_seg_idx == AW'(DEPTH - 1)) || (r_len_tbl[w_idx_inc] == '0);
    assign w_start_ok = start && !stop;

    // Segment table. Reads below see the pre-write contents on a same-cycle
    // write + start, so entry 0 is taken from its old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mode_tbl[i] <= DEFAULT_MODE;
                r_len_tbl[i]  <= '0;
            end
        end else if (wr_en && (r_state != c_run)) begin
            r_mode_tbl[wr_addr] <= wr_mode;
            r_len_tbl[wr_addr]  <= wr_len;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_idle;
            r_mode_out <= DEFAULT_MODE;
            r_seg_idx  <= '0;
            r_remain   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode_out <= w_mode_nxt;
            r_seg_idx  <= w_idx_nxt;
            r_remain   <= w_remain_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_wr_err   <= wr_en && (r_state == c_run);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_start_ok) begin
                    w_state_nxt = (r_len_tbl[0] == '0) ? c_fin : c_run;
                end
            end
            c_run: begin
                if (stop) begin
                    w_state_nxt = c_idle;
                end else if (w_seg_end && w_pass_end) begin
                    w_state_nxt = c_loop_en ? c_run : c_fin;
                end
            end
            c_fin:   w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Next values of the registered outputs and segment counter
    always_comb begin
        w_mode_nxt   = r_mode_out;
        w_idx_nxt    = r_seg_idx;
        w_remain_nxt = r_remain;
        w_done_nxt   = 1'b0;
        w_busy_nxt   = (w_state_nxt == c_run);
        case (r_state)
            c_idle: begin
                if (w_start_ok) begin
                    if (r_len_tbl[0] == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_mode_nxt   = r_mode_tbl[0];
                        w_idx_nxt    = '0;
                        w_remain_nxt = r_len_tbl[0];
                    end
                end
            end
            c_run: begin
                if (stop) begin
                    w_mode_nxt   = DEFAULT_MODE;
                    w_idx_nxt    = '0;
                    w_remain_nxt = '0;
                end else if (!w_seg_end) begin
                    w_remain_nxt = r_remain - LEN_W'(1);
                end else if (w_pass_end) begin
                    w_done_nxt = 1'b1;
                    w_idx_nxt  = '0;
                    if (c_loop_en) begin
                        // entry 0 is non-empty: playback could not have started otherwise
                        w_mode_nxt   = r_mode_tbl[0];
                        w_remain_nxt = r_len_tbl[0];
                    end else begin
                        w_mode_nxt   = DEFAULT_MODE;
                        w_remain_nxt = '0;
                    end
                end else begin
                    w_mode_nxt   = r_mode_tbl[w_idx_inc];
                    w_idx_nxt    = w_idx_inc;
                    w_remain_nxt = r_len_tbl[w_idx_inc];
                end
            end
            default: ;
        endcase
    end

    assign mode_out = r_mode_out;
    assign seg_idx  = r_seg_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wr_err   = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_mode_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_counter_mode_seq
// Description : Self-checking bench for counter_mode_seq. Each driven cycle
//               pushes the expected post-edge outputs into a scoreboard queue;
//               a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_mode_seq;

    localparam int         DEPTH = 8;
    localparam int         LEN_W = 8;
    localparam logic [1:0] DEF   = 2'd1;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             wr_en   = 1'b0;
    logic [2:0]       wr_addr = '0;
    logic [1:0]       wr_mode = '0;
    logic [LEN_W-1:0] wr_len  = '0;
    logic             start   = 1'b0;
    logic             stop    = 1'b0;
    logic [1:0]       mode_out;
    logic [2:0]       seg_idx;
    logic             busy;
    logic             done;
    logic             wr_err;

    counter_mode_seq #(
        .DEPTH        (DEPTH),
        .LEN_W        (LEN_W),
        .DEFAULT_MODE (DEF)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mode  (wr_mode),
        .wr_len   (wr_len),
        .start    (start),
        .stop     (stop),
        .mode_out (mode_out),
        .seg_idx  (seg_idx),
        .busy     (busy),
        .done     (done),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       chk;
        logic [1:0] mode;
        logic [2:0] idx;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Bench's own copy of the table, updated only by accepted writes
    logic [1:0]       tm[DEPTH];
    logic [LEN_W-1:0] tl[DEPTH];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic exp_t ex(input logic [1:0] m, input logic [2:0] i,
                                input logic b, input logic d, input logic e);
        exp_t r;
        r.chk = 1'b1; r.mode = m; r.idx = i; r.busy = b; r.done = d; r.err = e;
        return r;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                chk_eq("mode_out", 32'(mode_out), 32'(e.mode));
                chk_eq("seg_idx",  32'(seg_idx),  32'(e.idx));
                chk_eq("busy",     32'(busy),     32'(e.busy));
                chk_eq("done",     32'(done),     32'(e.done));
                chk_eq("wr_err",   32'(wr_err),   32'(e.err));
            end
        end
    end

    // One clock: queue the outputs expected after the coming edge, then advance
    task automatic step(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic clr_tbl();
        for (int i = 0; i < DEPTH; i++) begin
            tm[i] = DEF;
            tl[i] = '0;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] m, input logic [LEN_W-1:0] l);
        wr_en = 1'b1; wr_addr = a; wr_mode = m; wr_len = l;
        step(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        wr_en = 1'b0;
        tm[a] = m;
        tl[a] = l;
    endtask

    // Play one pass from the bench table. kill_at: item where stop (or reset
    // when kill_rst) is applied, -1 for none. wr_at: item carrying a write
    // (0 = same cycle as start). restart_at: item carrying an extra start.
    task automatic play(input int kill_at, input bit kill_rst, input int wr_at,
                        input int restart_at, input logic [2:0] wa,
                        input logic [1:0] wm, input logic [LEN_W-1:0] wl);
        exp_t lst[$];
        exp_t t;
        for (int s = 0; s < DEPTH; s++) begin
            if (tl[s] == '0) break;
            for (int c = 0; c < int'(tl[s]); c++)
                lst.push_back(ex(tm[s], 3'(s), 1'b1, 1'b0, 1'b0));
        end
        lst.push_back(ex(DEF, 3'd0, 1'b0, 1'b1, 1'b0));
        lst.push_back(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        if (kill_at > 0) begin
            while (lst.size() > kill_at) lst.delete(lst.size() - 1);
            lst.push_back(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
            lst.push_back(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        end
        if (wr_at > 0) begin
            t = lst[wr_at];
            t.err = 1'b1;
            lst[wr_at] = t;
        end
        wr_addr = wa; wr_mode = wm; wr_len = wl;
        for (int i = 0; i < lst.size(); i++) begin
            start = (i == 0) || (i == restart_at);
            stop  = (i == kill_at) && !kill_rst;
            rst   = !((i == kill_at) && kill_rst);
            wr_en = (i == wr_at);
            step(lst[i]);
        end
        start = 1'b0; stop = 1'b0; rst = 1'b1; wr_en = 1'b0;
        if (wr_at == 0) begin
            tm[wa] = wm;
            tl[wa] = wl;
        end
        if (kill_rst && kill_at > 0) clr_tbl();
    endtask

    initial begin : drv
        exp_t lp[$];
        clr_tbl();
        // Reset state
        rst = 1'b0;
        step(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        step(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        step(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        // Empty program after reset: immediate done, mode stays default
        play(-1, 1'b0, -1, -1, 3'd0, 2'd0, 8'd0);

`ifdef COUNTER_MODE_SEQ_LOOP_EN
        wr(3'd0, 2'd3, 8'd2);
        wr(3'd1, 2'd2, 8'd3);
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 5; c++)
                lp.push_back(ex((c < 2) ? 2'd3 : 2'd2, (c < 2) ? 3'd0 : 3'd1,
                                1'b1, (p > 0) && (c == 0), 1'b0));
        lp.push_back(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        lp.push_back(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < lp.size(); i++) begin
            start = (i == 0);
            stop  = (i == 15);
            step(lp[i]);
        end
        start = 1'b0; stop = 1'b0;
`else
        // start and stop together in IDLE: nothing happens
        wr(3'd0, 2'd2, 8'd17);
        start = 1'b1; stop = 1'b1;
        step(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        start = 1'b0; stop = 1'b0;
        step(ex(DEF, 3'd0, 1'b0, 1'b0, 1'b0));
        // Six-segment program, sum of lengths 60
        wr(3'd1, 2'd3, 8'd12);
        wr(3'd2, 2'd1, 8'd7);
        wr(3'd3, 2'd3, 8'd6);
        wr(3'd4, 2'd2, 8'd6);
        wr(3'd5, 2'd3, 8'd12);
        play(-1, 1'b0, -1, -1, 3'd0, 2'd0, 8'd0);
        // Stop in the middle of segment 2, then replay; second replay also
        // carries a start during FIN which must be ignored
        play(32, 1'b0, -1, -1, 3'd0, 2'd0, 8'd0);
        play(-1, 1'b0, -1, 61, 3'd0, 2'd0, 8'd0);
        // Write during RUN is rejected, extra start during RUN ignored
        play(-1, 1'b0, 5, 10, 3'd0, 2'd0, 8'd3);
        play(-1, 1'b0, -1, -1, 3'd0, 2'd0, 8'd0);
        // Write together with start: playback uses old entry 0, write lands
        play(-1, 1'b0, 0, -1, 3'd0, 2'd0, 8'd2);
        play(-1, 1'b0, -1, -1, 3'd0, 2'd0, 8'd0);
        // Reset mid-playback: no done, table cleared
        play(20, 1'b1, -1, -1, 3'd0, 2'd0, 8'd0);
        play(-1, 1'b0, -1, -1, 3'd0, 2'd0, 8'd0);
        // All entries length 1: seg_idx walks the full table, then wraps to done
        for (int i = 0; i < DEPTH; i++) wr(3'(i), 2'(i), 8'd1);
        play(-1, 1'b0, -1, -1, 3'd0, 2'd0, 8'd0);
        // Maximum segment length
        wr(3'd0, 2'd2, 8'd255);
        wr(3'd1, 2'd0, 8'd0);
        play(-1, 1'b0, -1, -1, 3'd0, 2'd0, 8'd0);
`endif
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
